ssd_display_driver: RTL and testbench
=====================================

Name: ssd_display_driver

Overview:
- Downstream consumer of the pipeline's 13-bit `ssd` debug output; drives a 4-digit, common-anode seven-segment display on the board.
- A sequential double-dabble converter turns the binary value into 4 BCD digits.
- A refresh counter time-multiplexes those digits onto the anodes, with optional leading-zero blanking.

Parameters:
- DATA_W, 13: width of the input value; max 8191 fits in 4 decimal digits.
- REFRESH_DIV, 100000: clock cycles each digit stays lit. Must be ≥1.
- BLANK_LZ, 1: 1 = blank leading zero digits; digit 0 is never blanked.

Ports:
- clk, input, 1: system clock; all state updates on its rising edge.
- rst, input, 1: synchronous, active-high reset.
- value, input, DATA_W: binary value to display (pipeline `ssd` output).
- anode, output, 4: active-low, one-hot digit enable; bit 0 = ones digit.
- segments, output, 7: active-low, ordered {g,f,e,d,c,b,a}.
- bcd_out, output, 16: committed BCD digits {thousands,hundreds,tens,ones}.
- bcd_valid, output, 1: one-cycle pulse when bcd_out is updated.
- busy, output, 1: high while a conversion is in progress.

Behaviour:
- Reset values (rst high at an edge): anode=4'b1110, segments=7'b1000000, bcd_out=0, bcd_valid=0, busy=0.
- Reset also clears the captured-value register, the refresh counter and the digit index. FSM goes to IDLE.
- Reset mid-conversion aborts the conversion; bcd_out is not updated.

FSM states: IDLE, CONV, COMMIT.
- IDLE, when value ≠ captured value at an edge (edge N):
  - latch value into captured and into the shift register;
  - clear the 16-bit BCD scratch; iteration count = 0;
  - go to CONV; busy=1.
- CONV, one iteration per edge (edges N+1 .. N+13, 13 iterations total):
  - for each BCD nibble ≥5, add 3;
  - then shift {scratch, shift register} left by 1.
  - After the 13th iteration, go to COMMIT.
- COMMIT (edge N+14):
  - bcd_out ← scratch;
  - bcd_valid=1 for exactly the cycle after edge N+14;
  - busy=0; go to IDLE.
- Latency: bcd_out reflects the new value 14 edges after the capturing edge.
- value changes while busy are ignored. On returning to IDLE, the mismatch is re-detected and a new conversion starts on the next edge; the final stable value is always displayed.
- value equal to the captured value: no conversion, no bcd_valid pulse. After reset, captured=0, so value=0 produces no conversion.

Scan:
- The refresh counter counts 0..REFRESH_DIV-1.
- On wrap, the digit index advances 0→1→2→3→0. With REFRESH_DIV=1 it advances every cycle.
- anode: index 0→1110, 1→1101, 2→1011, 3→0111. anode and segments are registered and change on the same edge.
- segments show the decode of bcd_out's nibble for the current index. Decode, {g..a}:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - nibble >9 → 1111111
- Blanking (BLANK_LZ=1): digit k>0 shows 1111111 when nibbles k..3 are all zero. The anode is still driven. Digit 0 always shows its numeral.
- Scanning continues uninterrupted during conversion and displays the old bcd_out until COMMIT.

Test Plan:
- Reset: rst high 2 cycles → anode=1110, segments=1000000, bcd_out=0, busy=0, bcd_valid=0; value=0 afterwards produces no busy.
- Conversion: value=1234 at edge N → busy 1 from N; bcd_out=16'h1234 and single bcd_valid pulse after edge N+14. Also 8191 → 16'h8191, and 9 → 16'h0009.
- Change while busy: value 100 then 4321 at N+5 → bcd_out=16'h0100 at N+14, then 16'h4321 after a second conversion; two valid pulses total.
- Scan (REFRESH_DIV=4, value 1234): anode steps 1110,1101,1011,0111 every 4 cycles. Segments are 0011001 (4), 0110000 (3), 0100100 (2), 1111001 (1) respectively, then wrap.
- Blanking: value 7, BLANK_LZ=1 → digit 0 = 1111000, digits 1–3 = 1111111. Value 1005 → no digit blanked (internal zeros kept).
- Reset mid-conversion: value 555, assert rst at N+6 → no bcd_valid, bcd_out=0. After release, conversion restarts and bcd_out=16'h0555 after 14 edges.

Source files
------------

// File: rtl/ssd_display_driver.sv
// Seven-segment driver: binary value to BCD via sequential double-dabble,
// then time-multiplexed onto a 4-digit common-anode display.
module ssd_display_driver #(
    parameter int DATA_W      = 13,
    parameter int REFRESH_DIV = 100000,
    parameter bit BLANK_LZ    = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] value,
    output logic [3:0]        anode,
    output logic [6:0]        segments,
    output logic [15:0]       bcd_out,
    output logic              bcd_valid,
    output logic              busy
);

    localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int CW = $clog2(DATA_W + 1);
    localparam int SW = 16 + DATA_W;

    typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;

    state_t            state;
    logic [DATA_W-1:0] captured;
    logic [DATA_W-1:0] shreg;
    logic [15:0]       scratch;
    logic [CW-1:0]     iter;
    logic [RW-1:0]     rcnt;
    logic [1:0]        idx;

    logic [15:0]       adj;
    logic [SW-1:0]     shifted;
    logic              rwrap;
    logic [1:0]        nidx;
    logic [3:0]        nib;
    logic              blank;

    function automatic logic [6:0] seg_dec(input logic [3:0] d);
        case (d)
            4'd0:    seg_dec = 7'b1000000;
            4'd1:    seg_dec = 7'b1111001;
            4'd2:    seg_dec = 7'b0100100;
            4'd3:    seg_dec = 7'b0110000;
            4'd4:    seg_dec = 7'b0011001;
            4'd5:    seg_dec = 7'b0010010;
            4'd6:    seg_dec = 7'b0000010;
            4'd7:    seg_dec = 7'b1111000;
            4'd8:    seg_dec = 7'b0000000;
            4'd9:    seg_dec = 7'b0010000;
            default: seg_dec = 7'b1111111;
        endcase
    endfunction

    // Double-dabble step: add-3 correction per nibble, then shift left.
    always_comb begin
        adj = scratch;
        for (int i = 0; i < 4; i++) begin
            if (adj[i*4 +: 4] >= 4'd5)
                adj[i*4 +: 4] = adj[i*4 +: 4] + 4'd3;
        end
        shifted = {adj[14:0], shreg, 1'b0};
    end

    // Next scan position and whether that digit is a leading zero.
    always_comb begin
        rwrap = (rcnt == RW'(REFRESH_DIV - 1));
        nidx  = rwrap ? idx + 2'd1 : idx;
        nib   = bcd_out[nidx*4 +: 4];
        case (nidx)
            2'd1:    blank = (bcd_out[15:4] == 12'd0);
            2'd2:    blank = (bcd_out[15:8] == 8'd0);
            2'd3:    blank = (bcd_out[15:12] == 4'd0);
            default: blank = 1'b0;
        endcase
        blank = blank & BLANK_LZ;
    end

    // Conversion FSM: capture on change, iterate DATA_W times, commit.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            captured  <= '0;
            shreg     <= '0;
            scratch   <= '0;
            iter      <= '0;
            bcd_out   <= '0;
            bcd_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            bcd_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (value != captured) begin
                        captured <= value;
                        shreg    <= value;
                        scratch  <= '0;
                        iter     <= '0;
                        busy     <= 1'b1;
                        state    <= CONV;
                    end
                end
                CONV: begin
                    scratch <= shifted[SW-1 -: 16];
                    shreg   <= shifted[DATA_W-1:0];
                    iter    <= iter + 1'b1;
                    if (iter == CW'(DATA_W - 1))
                        state <= COMMIT;
                end
                COMMIT: begin
                    bcd_out   <= scratch;
                    bcd_valid <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Refresh scan: anode and segments move together on each wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            rcnt     <= '0;
            idx      <= 2'd0;
            anode    <= 4'b1110;
            segments <= 7'b1000000;
        end else begin
            rcnt     <= rwrap ? '0 : rcnt + 1'b1;
            idx      <= nidx;
            anode    <= ~(4'b0001 << nidx);
            segments <= blank ? 7'b1111111 : seg_dec(nib);
        end
    end

endmodule

// File: tb/tb_ssd_display_driver.sv
// Directed bench for ssd_display_driver with a BCD scoreboard
// and scan/blanking pattern checks at REFRESH_DIV=4.
module tb_ssd_display_driver;

    logic        clk = 1'b0;
    logic        rst;
    logic [12:0] value;
    logic [3:0]  anode;
    logic [6:0]  segments;
    logic [15:0] bcd_out;
    logic        bcd_valid;
    logic        busy;

    int checks = 0;
    int failures = 0;
    int nvalid = 0;
    logic [15:0] sbq[$];

    ssd_display_driver #(
        .DATA_W(13),
        .REFRESH_DIV(4),
        .BLANK_LZ(1'b1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .value(value),
        .anode(anode),
        .segments(segments),
        .bcd_out(bcd_out),
        .bcd_valid(bcd_valid),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs,
                         input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every bcd_valid pulse consumes one expected result.
    always @(negedge clk) begin
        if (bcd_valid) begin
            nvalid++;
            check("sb_pending", 16'(sbq.size() != 0), 16'd1);
            if (sbq.size() != 0)
                check("sb_bcd", bcd_out, sbq.pop_front());
        end
    end

    task automatic convert(input logic [12:0] v, input logic [15:0] e,
                           input bit drive);
        int n0;
        if (drive) begin
            @(negedge clk);
            value = v;
        end
        sbq.push_back(e);
        n0 = nvalid;
        @(posedge clk); #1;
        check("busy_start", busy, 1);
        repeat (13) @(posedge clk);
        #1;
        check("busy_mid", busy, 1);
        check("valid_early", bcd_valid, 0);
        @(posedge clk); #1;
        check("bcd_commit", bcd_out, e);
        check("valid_pulse", bcd_valid, 1);
        check("busy_done", busy, 0);
        @(posedge clk); #1;
        check("valid_drop", bcd_valid, 0);
        check("valid_count", 16'(nvalid - n0), 16'd1);
    endtask

    task automatic scan_check(input logic [6:0] s0, input logic [6:0] s1,
                              input logic [6:0] s2, input logic [6:0] s3);
        logic [6:0] es[4];
        logic [3:0] ea[4];
        logic [3:0] prev;
        bit found;
        es = '{s0, s1, s2, s3};
        ea = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        found = 1'b0;
        prev = anode;
        for (int i = 0; i < 24 && !found; i++) begin
            @(negedge clk);
            if (prev == 4'b0111 && anode == 4'b1110)
                found = 1'b1;
            else
                prev = anode;
        end
        check("scan_sync", 16'(found), 16'd1);
        if (found) begin
            for (int d = 0; d < 4; d++) begin
                for (int c = 0; c < 4; c++) begin
                    check("scan_anode", 16'(anode), 16'(ea[d]));
                    check("scan_seg", 16'(segments), 16'(es[d]));
                    @(negedge clk);
                end
            end
            check("scan_wrap", 16'(anode), 16'b1110);
        end
    endtask

    initial begin
        int n0;
        rst = 1'b1;
        value = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_anode", 16'(anode), 16'b1110);
        check("rst_seg", 16'(segments), 16'b1000000);
        check("rst_bcd", bcd_out, 16'h0000);
        check("rst_busy", busy, 0);
        check("rst_valid", bcd_valid, 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("zero_busy", busy, 0);
        check("zero_nvalid", 16'(nvalid), 16'd0);

        convert(13'd1234, 16'h1234, 1'b1);
        convert(13'd8191, 16'h8191, 1'b1);
        convert(13'd9, 16'h0009, 1'b1);

        // Change while busy: the later value follows automatically.
        @(negedge clk);
        value = 13'd100;
        sbq.push_back(16'h0100);
        n0 = nvalid;
        @(posedge clk); #1;
        check("chg_busy", busy, 1);
        repeat (4) @(posedge clk);
        @(negedge clk);
        value = 13'd4321;
        sbq.push_back(16'h4321);
        repeat (10) @(posedge clk);
        #1;
        check("chg_first", bcd_out, 16'h0100);
        check("chg_valid1", bcd_valid, 1);
        @(posedge clk); #1;
        check("chg_rebusy", busy, 1);
        repeat (14) @(posedge clk);
        #1;
        check("chg_second", bcd_out, 16'h4321);
        check("chg_idle", busy, 0);
        @(posedge clk); #1;
        check("chg_pulses", 16'(nvalid - n0), 16'd2);

        convert(13'd1234, 16'h1234, 1'b1);
        scan_check(7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001);
        convert(13'd7, 16'h0007, 1'b1);
        scan_check(7'b1111000, 7'b1111111, 7'b1111111, 7'b1111111);
        convert(13'd1005, 16'h1005, 1'b1);
        scan_check(7'b0010010, 7'b1000000, 7'b1000000, 7'b1111001);

        // Reset mid-conversion aborts, then the value is reconverted.
        @(negedge clk);
        value = 13'd555;
        n0 = nvalid;
        repeat (6) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("abort_bcd", bcd_out, 16'h0000);
        check("abort_busy", busy, 0);
        check("abort_anode", 16'(anode), 16'b1110);
        @(negedge clk);
        rst = 1'b0;
        check("abort_nvalid", 16'(nvalid - n0), 16'd0);
        convert(13'd555, 16'h0555, 1'b0);

        check("sb_empty", 16'(sbq.size()), 16'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
